// File: rtl/keypad_scan_ctrl.sv
// Matrix keypad scanner: drives one column low at a time, samples the
// active-low rows after a settle delay, debounces whole-frame results and
// hands each new single-key press to the consumer over valid/ready.
`timescale 1ns/1ps
module keypad_scan_ctrl #(
    parameter int NROWS        = 4,
    parameter int NCOLS        = 4,
    parameter int COL_TICKS    = 100000,
    parameter int SETTLE_TICKS = 8,
    parameter int DEBOUNCE     = 4,
    parameter int KW           = $clog2(NROWS*NCOLS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [NROWS-1:0] row,
    output logic [NCOLS-1:0] col,
    output logic [KW-1:0]    key_code,
    output logic             key_valid,
    input  logic             key_ready,
    output logic             key_pressed,
    output logic             multi_key,
    output logic             overflow
);

    localparam int TW = $clog2(COL_TICKS);
    localparam int CW = $clog2(NCOLS);
    localparam logic [TW-1:0] SETTLE_T = TW'(SETTLE_TICKS);
    localparam logic [TW-1:0] LAST_T   = TW'(COL_TICKS-1);
    localparam logic [CW-1:0] LAST_C   = CW'(NCOLS-1);
    localparam logic [3:0]    DB_MAX   = 4'(DEBOUNCE);

    // Frame result / debounced state kinds; idx is forced to 0 unless KEY so
    // that a plain {kind, idx} compare tells states apart.
    typedef enum logic [1:0] {S_NONE = 2'd0, S_KEY = 2'd1, S_MULTI = 2'd2} kind_e;

    logic          started;
    logic [TW-1:0] tick;
    logic [CW-1:0] cidx;
    logic          col_last, sample, frame_end;

    logic [1:0]    fcnt, s_cnt;
    logic [KW-1:0] fidx, s_idx;

    kind_e         res_kind, prev_kind, st_kind;
    logic [KW-1:0] res_idx, prev_idx, st_idx;
    logic [3:0]    db_cnt, db_next;
    logic          change;

    logic          suppress;
    logic          ev;
    logic [KW-1:0] ev_code;

    assign col_last  = (cidx == LAST_C);
    assign sample    = started && (tick == SETTLE_T);
    assign frame_end = started && (tick == LAST_T) && col_last;

    // Columns stay released during the first cycle out of reset, then one-cold.
    assign col = started ? ~(NCOLS'(1) << cidx) : '1;

    // Column dwell counter and column index; frames run back to back.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            started <= 1'b0;
            tick    <= '0;
            cidx    <= '0;
        end else if (!started) begin
            started <= 1'b1;
        end else if (tick == LAST_T) begin
            tick <= '0;
            cidx <= col_last ? '0 : cidx + 1'b1;
        end else begin
            tick <= tick + 1'b1;
        end
    end

    // Fold the sampled rows into the frame accumulator: saturating count,
    // index of the first press seen in scan order.
    always_comb begin
        s_cnt = fcnt;
        s_idx = fidx;
        for (int i = 0; i < NROWS; i++) begin
            if (!row[i]) begin
                if (s_cnt == 2'd0) s_idx = KW'(i*NCOLS) + KW'(cidx);
                if (s_cnt != 2'd2) s_cnt = s_cnt + 2'd1;
            end
        end
    end

    // Frame accumulators: load at the settle tick, clear at frame end.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fcnt <= '0;
            fidx <= '0;
        end else if (frame_end) begin
            fcnt <= '0;
            fidx <= '0;
        end else if (sample) begin
            fcnt <= s_cnt;
            fidx <= s_idx;
        end
    end

    // Frame result and debounce decision.
    always_comb begin
        res_kind = S_NONE;
        res_idx  = '0;
        if (fcnt == 2'd1) begin
            res_kind = S_KEY;
            res_idx  = fidx;
        end else if (fcnt == 2'd2) begin
            res_kind = S_MULTI;
        end
        if ((res_kind == prev_kind) && (res_idx == prev_idx))
            db_next = (db_cnt == DB_MAX) ? db_cnt : db_cnt + 4'd1;
        else
            db_next = 4'd1;
        change = (db_next == DB_MAX) &&
                 !((res_kind == st_kind) && (res_idx == st_idx));
    end

    // Debounce history, stable state and the level flags; raises an internal
    // event for a newly accepted key unless a multi-press is still suppressing.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_kind   <= S_NONE;
            prev_idx    <= '0;
            db_cnt      <= '0;
            st_kind     <= S_NONE;
            st_idx      <= '0;
            key_pressed <= 1'b0;
            multi_key   <= 1'b0;
            suppress    <= 1'b0;
            ev          <= 1'b0;
            ev_code     <= '0;
        end else begin
            ev <= 1'b0;
            if (frame_end) begin
                prev_kind <= res_kind;
                prev_idx  <= res_idx;
                db_cnt    <= db_next;
                if (change) begin
                    st_kind <= res_kind;
                    st_idx  <= res_idx;
                    case (res_kind)
                        S_NONE: begin
                            key_pressed <= 1'b0;
                            multi_key   <= 1'b0;
                            suppress    <= 1'b0;
                        end
                        S_MULTI: begin
                            key_pressed <= 1'b0;
                            multi_key   <= 1'b1;
                            suppress    <= 1'b1;
                        end
                        default: begin
                            key_pressed <= 1'b1;
                            multi_key   <= 1'b0;
                            if (!suppress) begin
                                ev      <= 1'b1;
                                ev_code <= res_idx;
                            end
                        end
                    endcase
                end
            end
        end
    end

    // Event hand-off: load when free or being drained, otherwise drop and flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_code  <= '0;
            key_valid <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            overflow <= 1'b0;
            if (ev) begin
                if (!key_valid || key_ready) begin
                    key_code  <= ev_code;
                    key_valid <= 1'b1;
                end else begin
                    overflow <= 1'b1;
                end
            end else if (key_valid && key_ready) begin
                key_valid <= 1'b0;
            end
        end
    end

endmodule

// File: doc/keypad_scan_ctrl.md
Name: keypad_scan_ctrl

Overview:
Parametrised matrix-keypad scanner for the calculator front end. It drives one column low at a time and samples the active-low row lines after a settle delay. Each full-frame result is debounced across several frames. Each new debounced key press is delivered as a key index through a valid/ready handshake, with a multi-key (ghost) flag and an overflow flag.

Parameters:
NROWS, 4, number of row inputs (2..8)
NCOLS, 4, number of column outputs (2..8)
COL_TICKS, 100000, clk cycles each column is driven (1 ms at 100 MHz); must be > SETTLE_TICKS+1
SETTLE_TICKS, 8, cycles after the column drive before rows are sampled
DEBOUNCE, 4, consecutive identical frame results required to accept a new state (1..15)
KW, clog2(NROWS*NCOLS), key_code width (derived)

Ports:
clk  in  1  system clock, 100 MHz
rst_n  in  1  asynchronous active-low reset
row  in  NROWS  keypad rows, active-low, externally pulled up; row[i] = row i
col  out  NCOLS  keypad columns, one-cold while scanning
key_code  out  KW  key index = row_idx*NCOLS + col_idx
key_valid  out  1  key event pending
key_ready  in  1  consumer accepts the event
key_pressed  out  1  level: debounced state is exactly one key
multi_key  out  1  level: debounced state is two or more keys
overflow  out  1  one-cycle pulse: an event was dropped

Behaviour:
- Reset (async assert, sync release): col all ones; tick counter, column index, frame accumulators and debounce counter = 0; stable state = NONE. key_code=0, key_valid=0, key_pressed=0, multi_key=0, overflow=0, suppress=0.
- Scan: column index j runs 0..NCOLS-1. col = ~(1<<j) for COL_TICKS cycles, tick counter 0..COL_TICKS-1.
- At tick == SETTLE_TICKS, register row. Each low bit i counts as a press at (i, j): increment the frame press count, saturating at 2, and record the index of the first press.
- After the last tick of column NCOLS-1: frame end. Result = NONE (count 0), KEY(idx) (count 1) or MULTI (count 2). Accumulators clear; j wraps to 0.
- Frame period = NCOLS*COL_TICKS cycles. There are no idle gaps.
- Debounce at frame end:
  - If the result equals the previous frame result, the counter increments, saturating at DEBOUNCE; otherwise it loads 1.
  - When the counter reaches DEBOUNCE and the result differs from the stable state, stable state <= result.
- Stable-state transitions, updated the cycle after frame end:
  - NONE->KEY(k): event k; key_pressed=1.
  - KEY(a)->KEY(b), a != b: event b.
  - KEY->NONE: key_pressed=0; no event.
  - Any->MULTI: multi_key=1, key_pressed=0, suppress=1; no event.
  - MULTI->KEY: multi_key=0; no event while suppress=1.
  - ->NONE: clears suppress and multi_key.
  - A held key never repeats.
- Event delivery:
  - If key_valid=0, load key_code and set key_valid=1 the next cycle.
  - key_valid and key_code stay stable until a posedge with key_ready=1; key_valid then drops, unless a new event arrives in the same cycle, in which case the new code loads and key_valid stays 1.
  - If an event arrives while key_valid=1 and key_ready=0, the new event is dropped, the old code is kept, and overflow pulses for 1 cycle.
  - key_ready while key_valid=0 is ignored.
- Latency: from the first sampled press to key_valid is at most (DEBOUNCE+1) frames + 2 cycles.
- A bounce shorter than DEBOUNCE frames produces no event and no change to key_pressed.
- Reset mid-frame: all state clears immediately and scanning restarts at column 0. A pending event is lost.

Test Plan:
(Bench params: NROWS=NCOLS=4, COL_TICKS=16, SETTLE_TICKS=4, DEBOUNCE=3; frame = 64 cycles.)
1. Reset, no keys -> col cycles 1110,1101,1011,0111 with 16 cycles each. key_valid, key_pressed and multi_key stay 0 for 10 frames.
2. Model row 2 low whenever col 1 is driven, for 5 frames, with key_ready=1 -> exactly one key_valid pulse with key_code=9, arriving by the end of frame 4. key_pressed=1 until the key is released and 3 frames elapse.
3. Same press held 20 frames, then released -> one event only. key_pressed falls 3–4 frames after release.
4. Press (0,0) for 2 frames, release for 2 frames, repeat -> no event ever; key_pressed stays 0.
5. Keys 0 and 5 held together for 5 frames -> multi_key=1, no event. Release key 5 only -> multi_key=0, still no event. Release all, then press key 3 -> event key_code=3.
6. key_ready=0; press key 1 (released), then key 2 -> key_code stays 1 and overflow pulses once. Raise key_ready -> key_valid falls the next cycle. Assert rst_n=0 mid-frame -> outputs clear immediately.
